// File: rtl/l2_write_merge_buf_if.sv
`default_nettype none
// ============================================================================
// Module  : l2_write_merge_buf_if
// Brief   : Store-request and merged-line handshake bundle for the L2 write
//           merge buffer.
// Revision: 1.0
// ============================================================================
interface l2_write_merge_buf_if #(
    parameter int WORDS_PER_LINE = 4,
    parameter int BITS_PER_WORD  = 64,
    parameter int LINE_ADDR_W    = 28
);
    localparam int c_BPW_B  = BITS_PER_WORD / 8;
    localparam int c_WOFF_W = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
    localparam int c_BOFF_W = $clog2(c_BPW_B);
    localparam int c_LINE_W = WORDS_PER_LINE * BITS_PER_WORD;
    localparam int c_MASK_W = WORDS_PER_LINE * c_BPW_B;

    logic                     req_valid;
    logic                     req_ready;
    logic [LINE_ADDR_W-1:0]   req_line_addr;
    logic [c_WOFF_W-1:0]      req_w_off;
    logic [c_BOFF_W-1:0]      req_b_off;
    logic [2:0]               req_hsize;
    logic [BITS_PER_WORD-1:0] req_word;
    logic                     flush;
    logic                     out_valid;
    logic                     out_ready;
    logic [LINE_ADDR_W-1:0]   out_line_addr;
    logic [c_LINE_W-1:0]      out_line;
    logic [c_MASK_W-1:0]      out_mask;

    modport master (
        output req_valid, req_line_addr, req_w_off, req_b_off, req_hsize,
               req_word, flush, out_ready,
        input  req_ready, out_valid, out_line_addr, out_line, out_mask
    );

    modport slave (
        input  req_valid, req_line_addr, req_w_off, req_b_off, req_hsize,
               req_word, flush, out_ready,
        output req_ready, out_valid, out_line_addr, out_line, out_mask
    );
endinterface
`default_nettype wire

// File: rtl/l2_write_merge_buf.sv
`default_nettype none
// ============================================================================
// Module  : l2_write_merge_buf
// Brief   : Single-line write-combining buffer merging sub-line stores into a
//           held line image with a byte mask, drained over valid/ready.
// Revision: 1.0
// ============================================================================
module l2_write_merge_buf #(
    parameter int WORDS_PER_LINE = 4,
    parameter int BITS_PER_WORD  = 64,
    parameter int LINE_ADDR_W    = 28,
    parameter int TIMEOUT        = 16
) (
    input  logic                clk,
    input  logic                rst,
    l2_write_merge_buf_if.slave bus
);
    localparam int c_BPW_B     = BITS_PER_WORD / 8;
    localparam int c_LINE_B    = WORDS_PER_LINE * c_BPW_B;
    localparam int c_LINE_W    = WORDS_PER_LINE * BITS_PER_WORD;
    localparam int c_WOFF_W    = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
    localparam int c_BOFF_W    = $clog2(c_BPW_B);
    localparam int c_LOG2_BPW  = $clog2(c_BPW_B);
    localparam int c_CNT_W     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0] c_TO_LAST = c_CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                 r_state;
    logic [LINE_ADDR_W-1:0] r_addr;
    logic [c_LINE_W-1:0]    r_line;
    logic [c_LINE_B-1:0]    r_mask;
    logic [c_CNT_W-1:0]     r_cnt;
    logic                   r_out_valid;

    logic [2:0]             w_lsz;
    logic [c_BPW_B-1:0]     w_lane_sel;
    logic [WORDS_PER_LINE-1:0] w_word_hit;
    logic [c_LINE_B-1:0]    w_wr_mask;
    logic [c_LINE_W-1:0]    w_base_line;
    logic [c_LINE_B-1:0]    w_base_mask;
    logic [c_LINE_W-1:0]    w_merged_line;
    logic [c_LINE_B-1:0]    w_merged_mask;
    logic                   w_full;
    logic                   w_match;

    // Sizes wider than a word (e.g. WORD_64 on a 32-bit word) collapse to a full word.
    assign w_lsz = (bus.req_hsize > 3'(c_LOG2_BPW)) ? 3'(c_LOG2_BPW) : bus.req_hsize;

    // A lane is selected when it falls in the same size-aligned block as b_off.
    for (genvar gb = 0; gb < c_BPW_B; gb++) begin : g_lane
        assign w_lane_sel[gb] = ((c_BOFF_W'(gb) >> w_lsz) == (bus.req_b_off >> w_lsz));
    end

    for (genvar gw = 0; gw < WORDS_PER_LINE; gw++) begin : g_hit
        assign w_word_hit[gw] = (bus.req_w_off == c_WOFF_W'(gw));
    end

    // A fresh line in IDLE starts from zero data and an empty mask.
    assign w_base_line = (r_state == S_IDLE) ? '0 : r_line;
    assign w_base_mask = (r_state == S_IDLE) ? '0 : r_mask;

    for (genvar gw = 0; gw < WORDS_PER_LINE; gw++) begin : g_word
        for (genvar gb = 0; gb < c_BPW_B; gb++) begin : g_byte
            localparam int c_IDX = gw * c_BPW_B + gb;
            assign w_wr_mask[c_IDX] = w_word_hit[gw] & w_lane_sel[gb];
            assign w_merged_line[8*c_IDX +: 8] = w_wr_mask[c_IDX] ? bus.req_word[8*gb +: 8]
                                                                  : w_base_line[8*c_IDX +: 8];
        end
    end

    assign w_merged_mask = w_base_mask | w_wr_mask;
    assign w_full        = &w_merged_mask;
    assign w_match       = (bus.req_line_addr == r_addr);

    // Flush wins over a same-cycle matching store, so the store is held off.
    assign bus.req_ready = (r_state == S_IDLE) ||
                           ((r_state == S_FILL) && w_match && !bus.flush);

    assign bus.out_valid     = r_out_valid;
    assign bus.out_line_addr = r_addr;
    assign bus.out_line      = r_line;
    assign bus.out_mask      = r_mask;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_line      <= '0;
            r_mask      <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_addr <= bus.req_line_addr;
                        r_line <= w_merged_line;
                        r_mask <= w_merged_mask;
                        r_cnt  <= '0;
                        if (w_full) begin
                            r_state     <= S_DRAIN;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state <= S_FILL;
                        end
                    end
                end
                S_FILL: begin
                    if (bus.flush) begin
                        r_state     <= S_DRAIN;
                        r_out_valid <= 1'b1;
                    end else if (bus.req_valid && w_match) begin
                        r_line <= w_merged_line;
                        r_mask <= w_merged_mask;
                        r_cnt  <= '0;
                        if (w_full) begin
                            r_state     <= S_DRAIN;
                            r_out_valid <= 1'b1;
                        end
                    end else if (bus.req_valid) begin
                        // Conflicting line: drain first, the request stays pending upstream.
                        r_state     <= S_DRAIN;
                        r_out_valid <= 1'b1;
                    end else if (TIMEOUT != 0) begin
                        if (r_cnt == c_TO_LAST) begin
                            r_state     <= S_DRAIN;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (bus.out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_mask      <= '0;
                        r_cnt       <= '0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_l2_write_merge_buf.sv
`default_nettype none
// ============================================================================
// Module  : tb_l2_write_merge_buf
// Brief   : Directed vector table plus multi-cycle sequences for the merge buffer.
// Revision: 1.0
// ============================================================================
module tb_l2_write_merge_buf;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    l2_write_merge_buf_if #(.WORDS_PER_LINE(4), .BITS_PER_WORD(64), .LINE_ADDR_W(28)) bus_a();
    l2_write_merge_buf_if #(.WORDS_PER_LINE(4), .BITS_PER_WORD(64), .LINE_ADDR_W(28)) bus_b();

    l2_write_merge_buf #(.WORDS_PER_LINE(4), .BITS_PER_WORD(64), .LINE_ADDR_W(28), .TIMEOUT(16))
        dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
    l2_write_merge_buf #(.WORDS_PER_LINE(4), .BITS_PER_WORD(64), .LINE_ADDR_W(28), .TIMEOUT(0))
        dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [27:0]  addr;
        logic [1:0]   w_off;
        logic [2:0]   b_off;
        logic [2:0]   hsize;
        logic [63:0]  word;
        logic [31:0]  exp_mask;
        logic [255:0] exp_line;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_a(input logic [27:0] a, input logic [1:0] wo, input logic [2:0] bo,
                           input logic [2:0] hs, input logic [63:0] wd);
        bus_a.req_valid     = 1'b1;
        bus_a.req_line_addr = a;
        bus_a.req_w_off     = wo;
        bus_a.req_b_off     = bo;
        bus_a.req_hsize     = hs;
        bus_a.req_word      = wd;
    endtask

    task automatic drain_a();
        bus_a.out_ready = 1'b1;
        @(negedge clk);
        bus_a.out_ready = 1'b0;
        chk("drain_done_valid", bus_a.out_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        n_cmp = 0;
        n_err = 0;

        vecs[0] = '{28'h10,      2'd1, 3'd3, 3'd0, 64'hAABBCCDD_EEFF1122, 32'h0000_0800, 256'hEE << 88};
        vecs[1] = '{28'h33,      2'd2, 3'd5, 3'd1, 64'h01234567_89ABCDEF, 32'h0030_0000, 256'h4567 << 160};
        vecs[2] = '{28'hABCDEF0, 2'd3, 3'd6, 3'd2, 64'h01234567_89ABCDEF, 32'hF000_0000, 256'h01234567 << 224};
        vecs[3] = '{28'h1,       2'd0, 3'd7, 3'd3, 64'hDEADBEEF_CAFEF00D, 32'h0000_00FF, 256'hDEADBEEF_CAFEF00D};
        vecs[4] = '{28'hFFFFFFF, 2'd3, 3'd0, 3'd0, 64'hFFFFFFFF_FFFFFF5A, 32'h0100_0000, 256'h5A << 192};
        vecs[5] = '{28'h0,       2'd0, 3'd7, 3'd1, 64'h01234567_89ABCDEF, 32'h0000_00C0, 256'h0123 << 48};

        rst = 1'b0;
        bus_a.req_valid = 0; bus_a.req_line_addr = 0; bus_a.req_w_off = 0; bus_a.req_b_off = 0;
        bus_a.req_hsize = 0; bus_a.req_word = 0; bus_a.flush = 0; bus_a.out_ready = 0;
        bus_b.req_valid = 0; bus_b.req_line_addr = 0; bus_b.req_w_off = 0; bus_b.req_b_off = 0;
        bus_b.req_hsize = 0; bus_b.req_word = 0; bus_b.flush = 0; bus_b.out_ready = 0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", bus_a.req_ready, 1);
        chk("rst_out_valid", bus_a.out_valid, 0);
        chk("rst_out_mask",  bus_a.out_mask, 0);
        chk("rst_out_line",  bus_a.out_line, 0);
        chk("rst_out_addr",  bus_a.out_line_addr, 0);
        rst = 1'b1;
        @(negedge clk);

        // Single store + flush per vector.
        for (int i = 0; i < 6; i++) begin
            drive_a(vecs[i].addr, vecs[i].w_off, vecs[i].b_off, vecs[i].hsize, vecs[i].word);
            #1 chk("vec_idle_ready", bus_a.req_ready, 1);
            @(negedge clk);
            bus_a.req_valid = 0;
            bus_a.flush = 1;
            #1;
            chk("vec_flush_prio_ready", bus_a.req_ready, 0);
            chk("vec_fill_valid", bus_a.out_valid, 0);
            @(negedge clk);
            bus_a.flush = 0;
            chk("vec_out_valid", bus_a.out_valid, 1);
            chk("vec_out_mask",  bus_a.out_mask, vecs[i].exp_mask);
            chk("vec_out_line",  bus_a.out_line, vecs[i].exp_line);
            chk("vec_out_addr",  bus_a.out_line_addr, vecs[i].addr);
            drain_a();
        end

        // Four 64-bit stores fill the line and auto-drain.
        for (int w = 0; w < 4; w++) begin
            drive_a(28'h20, 2'(w), 3'd0, 3'd3, 64'(w + 1) * 64'h1111111111111111);
            #1;
            chk("fill_ready", bus_a.req_ready, 1);
            chk("fill_no_valid", bus_a.out_valid, 0);
            @(negedge clk);
        end
        bus_a.req_valid = 0;
        chk("fill_out_valid", bus_a.out_valid, 1);
        chk("fill_out_mask", bus_a.out_mask, 32'hFFFFFFFF);
        chk("fill_out_line", bus_a.out_line,
            256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111);
        chk("fill_out_addr", bus_a.out_line_addr, 28'h20);
        drain_a();

        // Conflicting line address forces a drain, then the new store lands after a bubble.
        drive_a(28'h5, 2'd0, 3'd0, 3'd0, 64'h00000000_000000AB);
        @(negedge clk);
        drive_a(28'h6, 2'd1, 3'd1, 3'd0, 64'h00000000_0000CD00);
        bus_a.out_ready = 1;
        #1 chk("conf_ready_low", bus_a.req_ready, 0);
        @(negedge clk);
        chk("conf_drain_valid", bus_a.out_valid, 1);
        chk("conf_drain_addr", bus_a.out_line_addr, 28'h5);
        chk("conf_drain_mask", bus_a.out_mask, 32'h1);
        chk("conf_drain_ready", bus_a.req_ready, 0);
        @(negedge clk);
        chk("conf_idle_valid", bus_a.out_valid, 0);
        chk("conf_idle_ready", bus_a.req_ready, 1);
        @(negedge clk);
        bus_a.req_valid = 0;
        bus_a.flush = 1;
        @(negedge clk);
        bus_a.flush = 0;
        chk("conf2_valid", bus_a.out_valid, 1);
        chk("conf2_addr", bus_a.out_line_addr, 28'h6);
        chk("conf2_mask", bus_a.out_mask, 32'h0000_0200);
        chk("conf2_line", bus_a.out_line, 256'hCD << 72);
        @(negedge clk);
        bus_a.out_ready = 0;
        chk("conf2_done", bus_a.out_valid, 0);

        // Halfword then overlapping byte, held under backpressure.
        drive_a(28'h9, 2'd0, 3'd2, 3'd1, 64'h00000000_BEEF0000);
        @(negedge clk);
        drive_a(28'h9, 2'd0, 3'd3, 3'd0, 64'h00000000_77000000);
        @(negedge clk);
        bus_a.req_valid = 0;
        bus_a.flush = 1;
        @(negedge clk);
        bus_a.flush = 0;
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", bus_a.out_valid, 1);
            chk("bp_line", bus_a.out_line, 256'h77EF0000);
            chk("bp_mask", bus_a.out_mask, 32'h0000_000C);
            @(negedge clk);
        end
        drain_a();

        // Timeout: drain 16 cycles after FILL entry.
        drive_a(28'h40, 2'd1, 3'd0, 3'd3, 64'h12345678_9ABCDEF0);
        @(negedge clk);
        bus_a.req_valid = 0;
        for (int k = 0; k <= 16; k++) begin
            chk("to_valid", bus_a.out_valid, (k == 16) ? 1 : 0);
            if (k < 16) @(negedge clk);
        end
        chk("to_mask", bus_a.out_mask, 32'h0000_FF00);
        drain_a();

        // TIMEOUT=0 never drains on its own.
        bus_b.req_valid = 1; bus_b.req_line_addr = 28'h41; bus_b.req_hsize = 3'd3;
        bus_b.req_word = 64'h1;
        @(negedge clk);
        bus_b.req_valid = 0;
        seen = 0;
        for (int k = 0; k < 100; k++) begin
            if (bus_b.out_valid) seen = 1;
            @(negedge clk);
        end
        chk("to0_never_valid", 1'(seen), 0);

        // Asynchronous reset in DRAIN discards the line immediately.
        drive_a(28'h50, 2'd1, 3'd0, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk);
        bus_a.req_valid = 0;
        bus_a.flush = 1;
        @(negedge clk);
        bus_a.flush = 0;
        chk("ar_pre_valid", bus_a.out_valid, 1);
        #2 rst = 1'b0;
        #1;
        chk("ar_valid_drop", bus_a.out_valid, 0);
        chk("ar_ready", bus_a.req_ready, 1);
        chk("ar_mask", bus_a.out_mask, 0);
        @(negedge clk);
        rst = 1'b1;
        drive_a(28'h77, 2'd2, 3'd0, 3'd0, 64'h99);
        @(negedge clk);
        bus_a.req_valid = 0;
        bus_a.flush = 1;
        @(negedge clk);
        bus_a.flush = 0;
        chk("ar_new_valid", bus_a.out_valid, 1);
        chk("ar_new_mask", bus_a.out_mask, 32'h0001_0000);
        chk("ar_new_line", bus_a.out_line, 256'h99 << 128);
        drain_a();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
